mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max wait cycles for m_ack before abort (1..65535).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have fetch ports f_cyc in 1 (request), f_adr in ADDR_W, f_ack out 1, f_err out 1, f_dat_o out DATA_W (read data).
REQ-007 SHALL have load/store ports l_cyc in 1, l_we in 1, l_adr in ADDR_W, l_dat_i in DATA_W, l_sel in DATA_W/8, l_ack out 1, l_err out 1, l_dat_o out DATA_W.
REQ-008 SHALL have memory ports m_cyc out 1, m_we out 1, m_adr out ADDR_W, m_dat_o out DATA_W, m_sel out DATA_W/8, m_dat_i in DATA_W, m_ack in 1.

Function
REQ-009 SHALL implement states IDLE, GNT_F, GNT_L, held in a registered state variable.
REQ-010 SHALL, in IDLE, sample f_cyc/l_cyc at the rising edge; single requester -> its grant state next cycle; no request -> stay IDLE.
REQ-011 SHALL, on simultaneous requests in IDLE, grant the port not granted last (round-robin via registered last_grant flag).
REQ-012 SHALL drive m_cyc=1 exactly while in GNT_F or GNT_L; request-to-m_cyc latency is one cycle.
REQ-013 SHALL, in GNT_F, drive m_adr=f_adr, m_we=0, m_sel=all ones, m_dat_o=0.
REQ-014 SHALL, in GNT_L, drive m_adr=l_adr, m_we=l_we, m_sel=l_sel, m_dat_o=l_dat_i.
REQ-015 SHALL drive m_we, m_adr, m_sel, m_dat_o to 0 in IDLE.
REQ-016 SHALL forward m_ack combinationally only to the granted port's ack; non-granted ack=0; m_ack in IDLE ignored.
REQ-017 SHALL route m_dat_i to both f_dat_o and l_dat_o; validity is qualified by the respective ack.
REQ-018 SHALL return to IDLE on the edge where m_ack=1 and update last_grant; one IDLE cycle separates transactions.
REQ-019 SHALL, if the granted requester drops its cyc before m_ack, return to IDLE next edge, forward no ack, leave last_grant unchanged.
REQ-020 SHALL keep a wait counter cleared on grant entry, incremented each granted cycle without m_ack, width ceil(log2(TIMEOUT+1)).
REQ-021 SHALL, when the counter equals TIMEOUT with m_ack=0, pulse the granted port's err for exactly that one cycle and return to IDLE next edge.
REQ-022 SHALL give m_ack priority over timeout when both occur in the same cycle (ack, no err).
REQ-023 SHALL never assert f_ack/f_err and l_ack/l_err in the same cycle.

Reset
REQ-024 SHALL, on rst=1, immediately force state=IDLE, counter=0, last_grant=LSU (fetch wins first tie).
REQ-025 SHALL hold all outputs at 0 during reset, including m_cyc, even mid-transaction.
REQ-026 SHALL resume arbitration on the first rising edge after rst deasserts.

Verification
REQ-027 Fetch only: f_cyc=1, f_adr=0x100, m_ack one cycle after m_cyc -> m_cyc high cycle N+1, m_adr=0x100, m_we=0, f_ack=1 with f_dat_o=m_dat_i, l_ack=0.
REQ-028 Simultaneous requests after reset, l_we=1, l_adr=0x2000, l_dat_i=0xDEADBEEF -> fetch granted first; after its ack plus one IDLE cycle, LSU granted with m_we=1, m_dat_o=0xDEADBEEF; third tie -> fetch again.
REQ-029 Timeout: TIMEOUT=4, l_cyc=1, m_ack never -> l_err single pulse on 5th granted cycle, m_cyc low next cycle, l_ack never asserted.
REQ-030 Ack at timeout: TIMEOUT=4, m_ack on 5th granted cycle -> ack delivered, err stays 0.
REQ-031 Reset mid-transaction: rst raised during GNT_L -> m_cyc=0 same cycle without clock edge; after release with both requesting, fetch granted first.
REQ-032 Abort: f_cyc dropped in 2nd granted cycle -> IDLE next edge, no f_ack/f_err, pending l_cyc granted following cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that shares one memory bus between an
// instruction fetch port and a load/store port, with an m_ack timeout abort.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  f_cyc,
  input  logic [ADDR_W-1:0]     f_adr,
  output logic                  f_ack,
  output logic                  f_err,
  output logic [DATA_W-1:0]     f_dat_o,
  // load/store port
  input  logic                  l_cyc,
  input  logic                  l_we,
  input  logic [ADDR_W-1:0]     l_adr,
  input  logic [DATA_W-1:0]     l_dat_i,
  input  logic [DATA_W/8-1:0]   l_sel,
  output logic                  l_ack,
  output logic                  l_err,
  output logic [DATA_W-1:0]     l_dat_o,
  // memory port
  output logic                  m_cyc,
  output logic                  m_we,
  output logic [ADDR_W-1:0]     m_adr,
  output logic [DATA_W-1:0]     m_dat_o,
  output logic [DATA_W/8-1:0]   m_sel,
  input  logic [DATA_W-1:0]     m_dat_i,
  input  logic                  m_ack
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_F, GNT_L} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } mem_req_t;

  state_t           state, state_nxt;
  logic             last_lsu, last_lsu_nxt;   // 1: LSU was granted most recently
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             g_cyc, g_ack, g_err;
  logic             timed_out;
  mem_req_t         mreq;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      last_lsu <= 1'b1;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      last_lsu <= last_lsu_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    last_lsu_nxt = last_lsu;
    g_cyc        = 1'b0;
    g_ack        = 1'b0;
    g_err        = 1'b0;
    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (f_cyc && l_cyc) state_nxt = last_lsu ? GNT_F : GNT_L;
        else if (f_cyc)     state_nxt = GNT_F;
        else if (l_cyc)     state_nxt = GNT_L;
      end
      GNT_F, GNT_L: begin
        g_cyc = (state == GNT_F) ? f_cyc : l_cyc;
        // Abandoned request: no ack/err forwarded and fairness history untouched.
        if (!g_cyc) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (m_ack) begin
          g_ack        = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
          last_lsu_nxt = (state == GNT_L);
        end else if (timed_out) begin
          g_err        = 1'b1;
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side request mux; everything reads zero while idle.
  always_comb begin
    mreq = '0;
    case (state)
      GNT_F: begin
        mreq.adr = f_adr;
        mreq.sel = '1;
      end
      GNT_L: begin
        mreq.we  = l_we;
        mreq.adr = l_adr;
        mreq.dat = l_dat_i;
        mreq.sel = l_sel;
      end
      default: mreq = '0;
    endcase
  end

  // Async reset clears state immediately, so m_cyc drops without an edge.
  assign m_cyc   = (state != IDLE);
  assign m_we    = mreq.we;
  assign m_adr   = mreq.adr;
  assign m_dat_o = mreq.dat;
  assign m_sel   = mreq.sel;

  assign f_ack   = g_ack && (state == GNT_F);
  assign f_err   = g_err && (state == GNT_F);
  assign l_ack   = g_ack && (state == GNT_L);
  assign l_err   = g_err && (state == GNT_L);

  assign f_dat_o = rst ? '0 : m_dat_i;
  assign l_dat_o = rst ? '0 : m_dat_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin ties, timeout, abort, async reset.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_cyc, l_cyc, l_we, m_ack;
  logic [ADDR_W-1:0] f_adr, l_adr;
  logic [DATA_W-1:0] l_dat_i, m_dat_i;
  logic [3:0]        l_sel;
  logic              f_ack, f_err, l_ack, l_err, m_cyc, m_we;
  logic [DATA_W-1:0] f_dat_o, l_dat_o, m_dat_o;
  logic [ADDR_W-1:0] m_adr;
  logic [3:0]        m_sel;

  int checks = 0;
  int passed = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .f_cyc(f_cyc), .f_adr(f_adr), .f_ack(f_ack), .f_err(f_err), .f_dat_o(f_dat_o),
    .l_cyc(l_cyc), .l_we(l_we), .l_adr(l_adr), .l_dat_i(l_dat_i), .l_sel(l_sel),
    .l_ack(l_ack), .l_err(l_err), .l_dat_o(l_dat_o),
    .m_cyc(m_cyc), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o), .m_sel(m_sel),
    .m_dat_i(m_dat_i), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Advance to 1ns after the next rising edge; inputs change there, checks follow #1.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    f_cyc = 0; l_cyc = 0; l_we = 0; m_ack = 0;
    f_adr = '0; l_adr = '0; l_dat_i = '0; l_sel = '0; m_dat_i = '0;
  endtask

  task automatic pulse_reset;
    rst = 1; tick; tick; rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs(); rst = 1;
    f_cyc = 1; l_cyc = 1; m_ack = 1; m_dat_i = 32'h1234_5678;
    tick; tick; #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL rst_mcyc: got %0h want 0", m_cyc); else passed++;
    checks++; if ({f_ack, f_err, l_ack, l_err} !== 4'b0) $display("FAIL rst_acks: got %b want 0000", {f_ack, f_err, l_ack, l_err}); else passed++;
    checks++; if ({f_dat_o, l_dat_o} !== 64'h0) $display("FAIL rst_dat: got %h want 0", {f_dat_o, l_dat_o}); else passed++;
    checks++; if ({m_we, m_adr, m_dat_o, m_sel} !== '0) $display("FAIL rst_mbus: got %h want 0", {m_we, m_adr, m_dat_o, m_sel}); else passed++;
    // Released with no requests: m_ack in IDLE must be ignored.
    idle_inputs(); m_ack = 1; rst = 0; tick; tick; #1;
    checks++; if ({m_cyc, f_ack, l_ack} !== 3'b0) $display("FAIL idle_ack_ignored: got %b want 000", {m_cyc, f_ack, l_ack}); else passed++;
    m_ack = 0;
  endtask

  task automatic test_fetch;
    idle_inputs(); f_cyc = 1; f_adr = 32'h100; #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL fetch_latency: got %0h want 0", m_cyc); else passed++;
    tick; #1;
    checks++; if (m_cyc !== 1'b1) $display("FAIL fetch_mcyc: got %0h want 1", m_cyc); else passed++;
    checks++; if (m_adr !== 32'h100) $display("FAIL fetch_adr: got %h want 100", m_adr); else passed++;
    checks++; if ({m_we, m_sel, m_dat_o} !== {1'b0, 4'hF, 32'h0}) $display("FAIL fetch_bus: got %h want %h", {m_we, m_sel, m_dat_o}, {1'b0, 4'hF, 32'h0}); else passed++;
    m_ack = 1; m_dat_i = 32'hCAFE_F00D; #1;
    checks++; if ({f_ack, f_err, l_ack, l_err} !== 4'b1000) $display("FAIL fetch_ack: got %b want 1000", {f_ack, f_err, l_ack, l_err}); else passed++;
    checks++; if (f_dat_o !== 32'hCAFE_F00D) $display("FAIL fetch_dat: got %h want cafef00d", f_dat_o); else passed++;
    tick; f_cyc = 0; m_ack = 0; #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL fetch_release: got %0h want 0", m_cyc); else passed++;
  endtask

  task automatic test_round_robin;
    idle_inputs(); pulse_reset();
    f_cyc = 1; f_adr = 32'h300;
    l_cyc = 1; l_we = 1; l_adr = 32'h2000; l_dat_i = 32'hDEAD_BEEF; l_sel = 4'hA;
    tick; #1;
    checks++; if ({m_cyc, m_adr, m_we} !== {1'b1, 32'h300, 1'b0}) $display("FAIL rr_first_fetch: got %h want %h", {m_cyc, m_adr, m_we}, {1'b1, 32'h300, 1'b0}); else passed++;
    m_ack = 1; #1;
    checks++; if ({f_ack, l_ack} !== 2'b10) $display("FAIL rr_first_ack: got %b want 10", {f_ack, l_ack}); else passed++;
    tick; m_ack = 0; #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL rr_idle_gap1: got %0h want 0", m_cyc); else passed++;
    tick; #1;
    checks++; if ({m_cyc, m_we, m_adr, m_dat_o, m_sel} !== {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hA})
      $display("FAIL rr_lsu_bus: got %h want %h", {m_cyc, m_we, m_adr, m_dat_o, m_sel}, {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hA}); else passed++;
    m_ack = 1; m_dat_i = 32'h0BAD_F00D; #1;
    checks++; if ({f_ack, l_ack, l_dat_o} !== {2'b01, 32'h0BAD_F00D}) $display("FAIL rr_lsu_ack: got %h want %h", {f_ack, l_ack, l_dat_o}, {2'b01, 32'h0BAD_F00D}); else passed++;
    tick; m_ack = 0; #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL rr_idle_gap2: got %0h want 0", m_cyc); else passed++;
    tick; #1;
    checks++; if ({m_cyc, m_adr, m_we} !== {1'b1, 32'h300, 1'b0}) $display("FAIL rr_third_fetch: got %h want %h", {m_cyc, m_adr, m_we}, {1'b1, 32'h300, 1'b0}); else passed++;
    m_ack = 1; tick; idle_inputs(); tick;
  endtask

  task automatic test_timeout;
    int errs;
    int acks;
    idle_inputs(); l_cyc = 1; l_adr = 32'h40; l_sel = 4'hF;
    errs = 0; acks = 0;
    tick;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if ({m_cyc, l_err} !== 2'b10) $display("FAIL to_wait_c%0d: got %b want 10", c, {m_cyc, l_err}); else passed++;
      tick;
    end
    #1;
    checks++; if ({l_err, l_ack, f_err, f_ack} !== 4'b1000) $display("FAIL to_err_pulse: got %b want 1000", {l_err, l_ack, f_err, f_ack}); else passed++;
    tick; #1;
    checks++; if ({m_cyc, l_err} !== 2'b00) $display("FAIL to_release: got %b want 00", {m_cyc, l_err}); else passed++;
    l_cyc = 0;
  endtask

  task automatic test_ack_at_timeout;
    idle_inputs(); l_cyc = 1; l_adr = 32'h44;
    tick; tick; tick; tick; tick;
    m_ack = 1; #1;
    checks++; if ({m_cyc, l_ack, l_err} !== 3'b110) $display("FAIL ackto_prio: got %b want 110", {m_cyc, l_ack, l_err}); else passed++;
    tick; idle_inputs(); #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL ackto_release: got %0h want 0", m_cyc); else passed++;
  endtask

  task automatic test_reset_mid;
    // Make fetch the most recent winner so only reset can restore fetch priority.
    idle_inputs(); f_cyc = 1; f_adr = 32'h500;
    tick; m_ack = 1; tick; idle_inputs();
    l_cyc = 1; l_adr = 32'h600; l_we = 1;
    tick; #1;
    checks++; if ({m_cyc, m_adr} !== {1'b1, 32'h600}) $display("FAIL rmid_gnt_l: got %h want %h", {m_cyc, m_adr}, {1'b1, 32'h600}); else passed++;
    #2; rst = 1; m_ack = 1; #1;
    checks++; if ({m_cyc, l_ack, m_we, m_adr} !== '0) $display("FAIL rmid_async: got %h want 0", {m_cyc, l_ack, m_we, m_adr}); else passed++;
    m_ack = 0; f_cyc = 1; f_adr = 32'h700;
    tick; tick; rst = 0;
    tick; #1;
    checks++; if ({m_cyc, m_adr, m_we} !== {1'b1, 32'h700, 1'b0}) $display("FAIL rmid_fetch_first: got %h want %h", {m_cyc, m_adr, m_we}, {1'b1, 32'h700, 1'b0}); else passed++;
    m_ack = 1; tick; idle_inputs(); tick;
  endtask

  task automatic test_abort;
    idle_inputs(); f_cyc = 1; f_adr = 32'h800;
    tick; #1;
    checks++; if (m_cyc !== 1'b1) $display("FAIL abort_gnt: got %0h want 1", m_cyc); else passed++;
    tick;
    f_cyc = 0; l_cyc = 1; l_adr = 32'h900; #1;
    checks++; if ({f_ack, f_err, l_ack, l_err} !== 4'b0) $display("FAIL abort_no_resp: got %b want 0000", {f_ack, f_err, l_ack, l_err}); else passed++;
    tick; #1;
    checks++; if (m_cyc !== 1'b0) $display("FAIL abort_idle: got %0h want 0", m_cyc); else passed++;
    tick; #1;
    checks++; if ({m_cyc, m_adr} !== {1'b1, 32'h900}) $display("FAIL abort_lsu_next: got %h want %h", {m_cyc, m_adr}, {1'b1, 32'h900}); else passed++;
    m_ack = 1; tick; idle_inputs(); tick;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_fetch();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
